// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - single-stage ALU with accumulator and valid/ready handshake
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic             out_valid_q;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] acc_q;
    logic             zero_q, carry_q, ovf_q, neg_q;
    logic             carry_d, ovf_d;
    logic [WIDTH-1:0] op_a;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic             xfer_in, xfer_out;

    // Single output register: a new request can land whenever the old result leaves
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        xfer_in  = in_valid && in_ready;
        xfer_out = out_valid_q && out_ready;
    end

    // Operation datapath; shifts carry an extra bit so the last bit out falls into it
    always_comb begin
        op_a    = acc_sel ? acc_q : a;
        shamt   = b[SHW-1:0];
        sum     = '0;
        shl_w   = '0;
        shr_w   = '0;
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (op)
            OP_OR:  res_d = op_a | b;
            OP_XOR: res_d = op_a ^ b;
            OP_ADD: begin
                sum     = {1'b0, op_a} + {1'b0, b};
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (op_a[MSB] == b[MSB]) && (res_d[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                sum     = {1'b0, op_a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (op_a[MSB] != b[MSB]) && (res_d[MSB] != op_a[MSB]);
            end
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(b))};
            OP_SHL: begin
                shl_w   = {1'b0, op_a} << shamt;
                res_d   = shl_w[WIDTH-1:0];
                carry_d = shl_w[WIDTH];
            end
            OP_SHR: begin
                shr_w   = {op_a, 1'b0} >> shamt;
                res_d   = shr_w[WIDTH:1];
                carry_d = shr_w[0];
            end
            default: res_d = op_a & b;
        endcase
    end

    // Output register and accumulator; both load only on an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            acc_q       <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
        end else if (xfer_in) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
            acc_q       <= res_d;
            zero_q      <= (res_d == '0);
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            neg_q       <= res_d[MSB];
        end else if (xfer_out) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;
endmodule
